// File: rtl/sipo_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sipo_pkg : shared constants and helpers for the SIPO receiver  | rev 1.0
// ---------------------------------------------------------------------------
package sipo_pkg;

  localparam int SIPO_WIDTH_DEFAULT = 4;

  function automatic int bit_count_w(input int width);
    return $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sipo_register_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sipo_register_if : serial input strobe + valid/ready word output  | rev 1.0
// ---------------------------------------------------------------------------
interface sipo_register_if
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH_DEFAULT
) ();

  logic             serial_in;
  logic             shift;
  logic             clear;
  logic [WIDTH-1:0] parallel_out;
  logic             out_valid;
  logic             out_ready;
  logic             overrun;

  modport master (
    output serial_in, shift, clear, out_ready,
    input  parallel_out, out_valid, overrun
  );

  modport slave (
    input  serial_in, shift, clear, out_ready,
    output parallel_out, out_valid, overrun
  );

endinterface
`default_nettype wire

// File: rtl/sipo_shift_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sipo_shift_core : bit assembly, bit counter and frame realign  | rev 1.0
// ---------------------------------------------------------------------------
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH     = SIPO_WIDTH_DEFAULT,
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire logic             clock,
  input  wire logic             reset,
  input  wire logic             serial_in_i,
  input  wire logic             shift_i,
  input  wire logic             clear_i,
  output logic                  word_done_o,
  output logic [WIDTH-1:0]      word_o
);

  localparam int            CW   = bit_count_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shifted;

  if (MSB_FIRST) begin : g_msb_first
    assign shifted = {sreg_q[WIDTH-2:0], serial_in_i};
  end else begin : g_lsb_first
    assign shifted = {serial_in_i, sreg_q[WIDTH-1:1]};
  end

  // The completing word includes the bit arriving on this edge.
  assign word_o = shifted;

  always_comb begin
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    word_done_o = 1'b0;
    if (clear_i) begin
      sreg_d = '0;
      cnt_d  = '0;
    end else if (shift_i) begin
      sreg_d = shifted;
      if (cnt_q == LAST) begin
        cnt_d       = '0;
        word_done_o = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sipo_register.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sipo_register : SIPO receiver with holding register and overrun flag | rev 1.0
// ---------------------------------------------------------------------------
module sipo_register
  import sipo_pkg::*;
#(
  parameter int WIDTH     = SIPO_WIDTH_DEFAULT,
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire logic       clock,
  input  wire logic       reset,
  sipo_register_if.slave  bus
);

  logic             word_done;
  logic [WIDTH-1:0] word;

  logic [WIDTH-1:0] hold_q, hold_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             consume;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clock       (clock),
    .reset       (reset),
    .serial_in_i (bus.serial_in),
    .shift_i     (bus.shift),
    .clear_i     (bus.clear),
    .word_done_o (word_done),
    .word_o      (word)
  );

  assign consume = valid_q && bus.out_ready;

  // A consume on the completing edge frees the slot for the new word.
  always_comb begin
    hold_d    = hold_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (consume) begin
      valid_d = 1'b0;
    end
    if (word_done) begin
      if (!valid_q || consume) begin
        hold_d  = word;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.parallel_out = hold_q;
  assign bus.out_valid    = valid_q;
  assign bus.overrun      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_sipo_register.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sipo_register : directed scoreboard bench, MSB-first and LSB-first DUTs
// ---------------------------------------------------------------------------
module tb_sipo_register;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sipo_register_if #(.WIDTH(4)) ia ();
  sipo_register_if #(.WIDTH(4)) ib ();

  sipo_register #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clock (clock),
    .reset (reset),
    .bus   (ia)
  );

  sipo_register #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clock (clock),
    .reset (reset),
    .bus   (ib)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Expected words awaiting consumption, one queue per DUT (0 = MSB, 1 = LSB)
  logic [3:0] sb0[$];
  logic [3:0] sb1[$];
  logic [3:0] m_sreg [2];
  logic [3:0] m_last [2];
  int         m_cnt  [2];
  logic       m_ovr  [2];

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb0.delete();
    sb1.delete();
    for (int i = 0; i < 2; i++) begin
      m_sreg[i] = 4'h0;
      m_last[i] = 4'h0;
      m_cnt[i]  = 0;
      m_ovr[i]  = 1'b0;
    end
  endtask

  // One clock: drive DUT d, predict, then check it at the following negedge.
  task automatic step(input int d, input logic sh, input logic sd, input logic clr,
                      input logic rdy, input logic rst, input string tag);
    logic [3:0] nw;
    logic       done;
    logic       consume;
    int         sz;
    logic [3:0] exp_out;
    logic       obs_v, obs_o;
    logic [3:0] obs_p;

    done    = 1'b0;
    nw      = 4'h0;
    sz      = (d == 0) ? sb0.size() : sb1.size();
    consume = (sz > 0) && rdy;

    reset        = rst;
    ia.shift     = (d == 0) ? sh  : 1'b0;
    ia.serial_in = (d == 0) ? sd  : 1'b0;
    ia.clear     = (d == 0) ? clr : 1'b0;
    ia.out_ready = (d == 0) ? rdy : 1'b0;
    ib.shift     = (d == 1) ? sh  : 1'b0;
    ib.serial_in = (d == 1) ? sd  : 1'b0;
    ib.clear     = (d == 1) ? clr : 1'b0;
    ib.out_ready = (d == 1) ? rdy : 1'b0;

    if (rst) begin
      model_reset();
    end else begin
      m_ovr[d] = 1'b0;
      if (clr) begin
        m_sreg[d] = 4'h0;
        m_cnt[d]  = 0;
      end else if (sh) begin
        nw = (d == 0) ? {m_sreg[d][2:0], sd} : {sd, m_sreg[d][3:1]};
        m_sreg[d] = nw;
        if (m_cnt[d] == 3) begin
          m_cnt[d] = 0;
          done     = 1'b1;
        end else begin
          m_cnt[d] = m_cnt[d] + 1;
        end
      end
      if (consume) begin
        if (d == 0) m_last[0] = sb0.pop_front();
        else        m_last[1] = sb1.pop_front();
      end
      if (done) begin
        sz = (d == 0) ? sb0.size() : sb1.size();
        if (sz == 0) begin
          if (d == 0) sb0.push_back(nw);
          else        sb1.push_back(nw);
        end else begin
          m_ovr[d] = 1'b1;
        end
      end
    end

    @(posedge clock);
    @(negedge clock);

    sz      = (d == 0) ? sb0.size() : sb1.size();
    exp_out = (sz == 0) ? m_last[d] : ((d == 0) ? sb0[0] : sb1[0]);
    obs_v   = (d == 0) ? ia.out_valid    : ib.out_valid;
    obs_o   = (d == 0) ? ia.overrun      : ib.overrun;
    obs_p   = (d == 0) ? ia.parallel_out : ib.parallel_out;
    chk({tag, "/out_valid"},    {3'b0, obs_v}, {3'b0, (sz > 0)});
    chk({tag, "/overrun"},      {3'b0, obs_o}, {3'b0, m_ovr[d]});
    chk({tag, "/parallel_out"}, obs_p,         exp_out);
  endtask

  task automatic send_word(input int d, input logic [3:0] bits, input logic rdy_last, input string tag);
    for (int i = 3; i >= 0; i--) begin
      step(d, 1'b1, bits[i], 1'b0, (i == 0) ? rdy_last : 1'b0, 1'b0, tag);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] w;
    model_reset();
    ia.shift = 1'b0; ia.serial_in = 1'b0; ia.clear = 1'b0; ia.out_ready = 1'b0;
    ib.shift = 1'b0; ib.serial_in = 1'b0; ib.clear = 1'b0; ib.out_ready = 1'b0;

    // Reset held two cycles
    step(0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "reset_a");
    step(1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "reset_b");

    // MSB-first word 1,0,1,0 then consume
    send_word(0, 4'b1010, 1'b0, "msb_word");
    step(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "msb_consume");
    step(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "msb_idle");

    // LSB-first word 0,1,0,1 with the strobe toggling every other cycle
    w = 4'b0101;
    for (int i = 3; i >= 0; i--) begin
      step(1, 1'b1, w[i], 1'b0, 1'b0, 1'b0, "lsb_bit");
      step(1, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, "lsb_gap");
    end
    step(1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "lsb_consume");

    // Back-to-back: 1111 held, consumed on the edge that completes 0011
    send_word(0, 4'b1111, 1'b0, "b2b_first");
    send_word(0, 4'b0011, 1'b1, "b2b_second");
    step(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "b2b_consume");

    // Overrun: consumer stalled across two words
    send_word(0, 4'b1010, 1'b0, "ovr_first");
    send_word(0, 4'b0110, 1'b0, "ovr_second");
    step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "ovr_after");
    step(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "ovr_consume");

    // Clear mid-word (its shift is ignored)
    step(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "clr_pre");
    step(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "clr_pre");
    step(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "clr_edge");
    send_word(0, 4'b0101, 1'b0, "clr_word");
    step(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "clr_consume");

    // Reset mid-word; no word until four fresh bits
    step(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "rst_pre");
    step(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "rst_pre");
    step(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "rst_edge");
    send_word(0, 4'b0101, 1'b0, "rst_word");
    step(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "rst_consume");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
